cacheline_mem_arbiter: RTL
==========================

Name: cacheline_mem_arbiter

Overview:
- Shares the single physical-memory cacheline port between the I-cache (fetch-side miss/fill) and the D-cache (load/store-side miss, fill and writeback).
- Sits between the two cache controllers and the memory/L2 interface, below the pipelined RV32I datapath driven by the decoded control word.
- Captures one request per transaction, forwards it to memory, and routes the response back to the requester that was granted.

Parameters:
- ADDR_WIDTH, 32, byte address width of cacheline requests
- LINE_WIDTH, 256, cacheline data width in bits

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_addr  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, level, held until d_resp
- d_write  in  1  D-cache line writeback request, level, held until d_resp
- d_addr  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache writeback data
- d_rdata  out  LINE_WIDTH  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read command, held until mem_resp
- mem_write  out  1  memory write command, held until mem_resp
- mem_addr  out  ADDR_WIDTH  memory line address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse
- busy  out  1  high whenever state is not IDLE

Behaviour:
- FSM states and transitions:
  - IDLE: on any request, go to SERVE_D or SERVE_I.
  - SERVE_I and SERVE_D: on mem_resp, return to IDLE.
- Arbitration:
  - Sampled in IDLE only. Fixed priority: D-side wins over I-side.
  - d_read and d_write both high is a protocol error; write wins.
- Grant edge:
  - Registers the winner's op (read/write), address and wdata into capture registers.
  - mem_* are driven from the capture registers only, never from live requester inputs.
- Latency: request high in IDLE at cycle N gives mem_read/mem_write high in cycle N+1. Minimum transaction length is 2 cycles.
- mem_read/mem_write stay high through the cycle mem_resp is seen. They drop in the cycle after.
- Response routing is combinational, in the same cycle as mem_resp:
  - i_resp or d_resp = mem_resp qualified by state.
  - i_rdata = d_rdata = mem_rdata at all times; only the resp pulse is steered.
- After mem_resp at cycle R, state is IDLE at R+1. Requesters must deassert in R+1 unless issuing a new request. A request still high at R+1 is treated as new.
- A requester arriving while the other is being served waits. It is granted in the first IDLE cycle.
- Requester dropping its request mid-service: the transaction completes to memory. The resp pulse is still emitted; the requester ignores it.
- mem_resp in IDLE is ignored: no resp pulse, no state change.
- Reset (async, any time including mid-transaction):
  - State goes to IDLE; mem_read, mem_write, i_resp, d_resp, busy = 0.
  - mem_addr and mem_wdata capture registers = 0.
  - A memory response in flight at reset is dropped by the IDLE rule.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register (reset = I) is updated on every grant.
  - When both sides request in IDLE, the side not equal to last_grant wins. The first conflict after reset goes to D.
  - Uncontended requests are granted as without the macro.
- Undefined: fixed D-over-I priority; no last_grant register.

Test Plan:
- Lone I read:
  - Stimulus: i_read=1, i_addr=0x0000_0060 at cycle 0; mem_resp=1, mem_rdata=0xA5..A5 at cycle 5.
  - Response: mem_read=1 and mem_addr=0x60 in cycles 1-5; i_resp=1 only in cycle 5; i_rdata=0xA5..A5; d_resp=0 throughout.
- Simultaneous I read and D read at cycle 0, each mem_resp 3 cycles after command:
  - D granted first: mem_addr=d_addr in cycles 1-4, d_resp at cycle 4.
  - I granted next: mem_addr=i_addr in cycles 6-9, i_resp at cycle 9.
- D writeback:
  - Stimulus: d_write=1, d_addr=0x100, d_wdata=0x1234..; d_wdata changes after cycle 1.
  - Response: mem_write=1, mem_wdata holds the cycle-0 captured value until mem_resp; mem_read=0.
- I request at cycle 2 while D is being served from cycle 1:
  - i_read is ignored until d_resp.
  - mem_read for I starts exactly 2 cycles after d_resp.
- Reset mid-transaction:
  - Stimulus: rst_n=0 at cycle 3 of an I read.
  - Response: mem_read, busy and resp go to 0 immediately; a later mem_resp produces no i_resp/d_resp.
- With ARB_ROUND_ROBIN_EN, four back-to-back contended rounds with both sides always requesting:
  - Grant order is D, I, D, I. Without the macro the order is D, D, D, D.

Source files
------------

// File: rtl/cacheline_mem_arbiter.sv
// ============================================================================
// cacheline_mem_arbiter
// Shares one memory cacheline port between the I-cache and the D-cache.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention
// (default build: fixed D-over-I priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cacheline_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e state;

    logic i_req;
    logic d_req;
    logic d_wins;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // High when the most recent grant went to the D-side; reset value means I.
    logic last_grant_d;
    assign d_wins = d_req & (~i_req | ~last_grant_d);
`else
    assign d_wins = d_req;
`endif

    // Read data is broadcast; only the completion pulse is steered.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_resp  = mem_resp & (state == SERVE_I);
    assign d_resp  = mem_resp & (state == SERVE_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state     <= SERVE_D;
                        busy      <= 1'b1;
                        // Simultaneous read and write is illegal; the write wins.
                        mem_write <= d_write;
                        mem_read  <= ~d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d <= 1'b1;
`endif
                    end else if (i_req) begin
                        state     <= SERVE_I;
                        busy      <= 1'b1;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= i_addr;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
